pss_multi_peak_detector: RTL

Parametrised successor to the three-way PSS peak stage. It takes NUM_CH packed correlator magnitude streams and runs a per-channel sliding-window peak test against a programmable threshold. Simultaneous peaks are arbitrated by largest value, and the winner is reported with its N_id_2, peak value and sample index. A search/holdoff/locked state machine suppresses repeat detections and supports one-shot and continuous modes. It sits between the PSS correlators and the timing/SSS stages.

---
 rtl/pss_pkg.sv | 16 +
 rtl/pss_multi_peak_detector_if.sv | 29 ++
 rtl/pss_window_peak.sv | 66 ++++++
 rtl/pss_multi_peak_detector.sv | 133 +++++++++++++
 4 files changed

// File: rtl/pss_pkg.sv
// Shared types for the PSS multi-channel peak detector: FSM state encoding
// and the channel-index width helper.
package pss_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_LOCKED  = 2'd2
  } pss_state_e;

  // Channel index width, never narrower than one bit.
  function automatic int pss_ch_width(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/pss_multi_peak_detector_if.sv
// Correlator input stream and detection result bundle of the PSS peak detector.
interface pss_multi_peak_detector_if #(
  parameter int NUM_CH = 3,
  parameter int IN_DW  = 32,
  parameter int CNT_W  = 32,
  parameter int CH_W   = 2
);

  // Handshake: the stream has no ready; every cycle with s_axis_in_tvalid high
  // delivers one sample per channel and is always consumed. N_id_2_valid_o is a
  // one-cycle strobe; the result fields stay stable until the next strobe.
  logic [NUM_CH*IN_DW-1:0] s_axis_in_tdata;
  logic                    s_axis_in_tvalid;
  logic [CH_W-1:0]         N_id_2_o;
  logic                    N_id_2_valid_o;
  logic [IN_DW-1:0]        peak_value_o;
  logic [CNT_W-1:0]        peak_index_o;

  modport master (
    output s_axis_in_tdata, s_axis_in_tvalid,
    input  N_id_2_o, N_id_2_valid_o, peak_value_o, peak_index_o
  );

  modport slave (
    input  s_axis_in_tdata, s_axis_in_tvalid,
    output N_id_2_o, N_id_2_valid_o, peak_value_o, peak_index_o
  );

endinterface

// File: rtl/pss_window_peak.sv
// One channel's 2W+1 sliding window: shift register, fill tracking and the
// centre-sample peak test evaluated as the newest sample arrives.
module pss_window_peak #(
  parameter int IN_DW      = 32,
  parameter int WINDOW_LEN = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic             clear_i,
  input  logic [IN_DW-1:0] sample_i,
  input  logic [IN_DW-1:0] threshold_i,
  output logic             peak_o,
  output logic [IN_DW-1:0] centre_o
);

  localparam int TAPS   = 2 * WINDOW_LEN;
  localparam int FILL_W = $clog2(TAPS + 1);

  // win_q[0] is the newest stored sample; sample_i completes the 2W+1 window.
  logic [IN_DW-1:0]  win_q [TAPS];
  logic [IN_DW-1:0]  win_d [TAPS];
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              is_peak;

  always_comb begin
    fill_d = fill_q;
    for (int i = 0; i < TAPS; i++) win_d[i] = win_q[i];
    if (clear_i) begin
      fill_d = '0;
      for (int i = 0; i < TAPS; i++) win_d[i] = '0;
    end else if (valid_i) begin
      win_d[0] = sample_i;
      for (int i = 1; i < TAPS; i++) win_d[i] = win_q[i-1];
      if (fill_q != FILL_W'(TAPS)) fill_d = fill_q + FILL_W'(1);
    end
  end

  assign centre_o = win_q[WINDOW_LEN-1];

  // Newer neighbours allow equality so the first sample of a plateau wins.
  always_comb begin
    is_peak = (fill_q == FILL_W'(TAPS)) && (centre_o > threshold_i) &&
              (centre_o >= sample_i);
    for (int i = 0; i < TAPS; i++) begin
      if (i < WINDOW_LEN - 1) begin
        if (centre_o < win_q[i]) is_peak = 1'b0;
      end else if (i >= WINDOW_LEN) begin
        if (centre_o <= win_q[i]) is_peak = 1'b0;
      end
    end
  end

  assign peak_o = valid_i && is_peak;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fill_q <= '0;
      for (int i = 0; i < TAPS; i++) win_q[i] <= '0;
    end else begin
      fill_q <= fill_d;
      for (int i = 0; i < TAPS; i++) win_q[i] <= win_d[i];
    end
  end

endmodule

// File: rtl/pss_multi_peak_detector.sv
// NUM_CH-way PSS peak detector: per-channel window peaks, largest-value
// arbitration, sample indexing and a search/holdoff/locked detection FSM.
module pss_multi_peak_detector
  import pss_pkg::*;
#(
  parameter int IN_DW       = 32,
  parameter int NUM_CH      = 3,
  parameter int WINDOW_LEN  = 8,
  parameter int HOLDOFF_LEN = 1024,
  parameter int CNT_W       = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  pss_multi_peak_detector_if.slave    bus,
  input  logic [IN_DW-1:0]            threshold_i,
  input  logic                        mode_i,
  input  logic                        clear_i,
  output logic [1:0]                  state_o
);

  localparam int CH_W = pss_ch_width(NUM_CH);
  localparam int HO_W = $clog2(HOLDOFF_LEN + 1);

  logic [NUM_CH-1:0] ch_peak;
  logic [IN_DW-1:0]  ch_centre [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pss_window_peak #(
      .IN_DW      (IN_DW),
      .WINDOW_LEN (WINDOW_LEN)
    ) u_win (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .valid_i     (bus.s_axis_in_tvalid),
      .clear_i     (clear_i),
      .sample_i    (bus.s_axis_in_tdata[g*IN_DW +: IN_DW]),
      .threshold_i (threshold_i),
      .peak_o      (ch_peak[g]),
      .centre_o    (ch_centre[g])
    );
  end

  // Strict greater-than keeps the lowest channel on equal values.
  logic             any_peak;
  logic [CH_W-1:0]  best_ch;
  logic [IN_DW-1:0] best_val;

  always_comb begin
    any_peak = 1'b0;
    best_ch  = '0;
    best_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_peak[c] && (!any_peak || ch_centre[c] > best_val)) begin
        any_peak = 1'b1;
        best_ch  = CH_W'(c);
        best_val = ch_centre[c];
      end
    end
  end

  pss_state_e       state_q, state_d;
  logic [HO_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  nid_q, nid_d;
  logic [IN_DW-1:0] val_q, val_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             strobe_q, strobe_d;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    nid_d    = nid_q;
    val_d    = val_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    if (bus.s_axis_in_tvalid) cnt_d = cnt_q + CNT_W'(1);
    if (clear_i) begin
      state_d = ST_SEARCH;
      hold_d  = '0;
    end else if (bus.s_axis_in_tvalid) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (any_peak) begin
            strobe_d = 1'b1;
            nid_d    = best_ch;
            val_d    = best_val;
            // cnt_q is the index of the sample completing the window.
            idx_d    = cnt_q - CNT_W'(WINDOW_LEN);
            if (mode_i) begin
              state_d = ST_HOLDOFF;
              hold_d  = HO_W'(HOLDOFF_LEN);
            end else begin
              state_d = ST_LOCKED;
            end
          end
        end
        ST_HOLDOFF: begin
          hold_d = hold_q - HO_W'(1);
          if (hold_q <= HO_W'(1)) state_d = ST_SEARCH;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_SEARCH;
      hold_q   <= '0;
      cnt_q    <= '0;
      nid_q    <= '0;
      val_q    <= '0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      nid_q    <= nid_d;
      val_q    <= val_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.N_id_2_o       = nid_q;
  assign bus.N_id_2_valid_o = strobe_q;
  assign bus.peak_value_o   = val_q;
  assign bus.peak_index_o   = idx_q;
  assign state_o            = state_q;

endmodule
